usb_rx_phy_ms: RTL and testbench
================================

Name: usb_rx_phy_ms

Overview:
Multi-speed USB 1.1 receive PHY, successor to the fixed-rate soft RX PHY. It recovers bit timing from D+/D- with a phase accumulator DPLL and performs NRZI decode, bit-unstuffing, SYNC search and EOP detection. Unlike its predecessor it selects full speed (12 Mbit/s) or low speed (1.5 Mbit/s) at run time and reports stuff and framing errors. It sits between the pad synchronisers and the SIE, delivering byte-wide data with single-cycle valid pulses.

Parameters:
C_clk_input_hz, 48000000, system clock frequency; must be >= 48 MHz (4x FS bit rate), checked at elaboration.
C_PA_bits, 10, phase accumulator width.
C_PA_inc_fs, 2**C_PA_bits*12000000/C_clk_input_hz, derived FS increment; not overridden.
C_PA_inc_ls, 2**C_PA_bits*1500000/C_clk_input_hz, derived LS increment; not overridden.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
speed_low  in  1  0 = FS, 1 = LS; latched only in IDLE.
usb_dif  in  1  differential receiver output.
usb_dp  in  1  single-ended D+.
usb_dn  in  1  single-ended D-.
rx_en  in  1  receiver enable.
linestate  out  2  {dn,dp}, after 2-flop synchronisation.
clk_recovered_edge  out  1  one-cycle bit-sample strobe.
rx_active  out  1  high from end of SYNC to EOP or error.
valid  out  1  one-cycle pulse, data holds a new byte.
data  out  8  received byte, LSB first on wire.
rx_error  out  1  one-cycle pulse on stuff or framing error.
eop  out  1  one-cycle pulse on EOP at byte boundary.

Behaviour:
- Reset (synchronous; also rx_en=0): state IDLE, PA=0, all outputs 0, data=0, shift and counter registers 0. No pulses are generated.
- Input path: usb_dif, usb_dp and usb_dn each pass through a 2-flop synchroniser. SE0 = both synced dp and dn low.
- DPLL: R_PA += inc each clk. inc = C_PA_inc_ls if the latched speed is LS, else C_PA_inc_fs.
  - Strobe (clk_recovered_edge) fires on a 0->1 transition of the PA MSB, i.e. mid-bit.
  - A synced dif change while not SE0 loads PA=0 (phase realign). During SE0 the PA freewheels.
- NRZI decode at each strobe: bit = 1 if line equals the previous line bit, else 0. Decode is polarity-agnostic, so LS J/K inversion needs no special handling.
- Stuff counter counts consecutive 1s and clears on 0.
  - After 6 ones, the next strobed bit is a stuff bit and is discarded.
  - If that stuff bit is 1, it is a stuff error.
- FSM IDLE:
  - rx_active=0 in this state.
  - The last 8 decoded bits are kept in arrival order.
  - When they equal 0,0,0,0,0,0,0,1 (SYNC), go to DATA. rx_active=1 one clk after that strobe.
  - Bit count and stuff counter clear on entry. The speed latch freezes on entry.
- FSM DATA: each non-stuff bit shifts in at the MSB (shift right) and bitcnt increments mod 8.
  - On the 8th bit: data <= shift value, valid=1 for one clk, one clk after the strobe.
  - Stuff error: rx_error pulse, rx_active=0, go to DRAIN.
  - SE0 at a strobe with bitcnt==0: eop pulse, rx_active=0, go to IDLE.
  - SE0 at a strobe with bitcnt!=0: rx_error pulse (framing), no eop, go to IDLE.
- FSM DRAIN: rx_active=0, no valid pulses. Go to IDLE on the first strobe that samples SE0 (no eop pulse).
- Priorities at the same strobe: SE0 over stuff error over byte completion.
  - A byte completing on a 6th consecutive one still pulses valid; the following stuff bit is discarded.
- rx_en deasserted in any state: go to IDLE next clk, outputs cleared, any pending pulse suppressed. Synchronous reset mid-frame behaves identically.
- data holds its value until the next valid; it is not cleared at EOP.
- linestate is unaffected by rx_en and the FSM.

Test Plan:
1. FS, 48 MHz: idle J, SYNC, bytes 0xA5 0x3C, 2-bit SE0 EOP -> two valid pulses with data=0xA5 then 0x3C, then eop=1 for one clk; rx_error never asserted.
2. FS, payload 0xFF 0xFF with correct stuff bits -> data 0xFF twice, rx_active continuous, no rx_error.
3. FS, 7 consecutive 1s (no stuff bit) after 0xFF -> rx_error pulse, rx_active falls, no further valid until after SE0 plus a new SYNC.
4. FS, SE0 after 12 data bits -> one valid (first byte), then rx_error pulse, eop stays 0, state back in IDLE.
5. speed_low=1, LS packet 0x5A with J=dn-high polarity -> data=0x5A. Toggling speed_low mid-frame must not disturb reception.
6. FS with bit rate +0.25% and -0.25%, 8-byte packet, plus rx_en dropped mid-byte in a second packet -> all bytes correct in the first; second produces no valid/eop/rx_error after the drop.

Source files
------------

// File: rtl/usb_rx_phy_ms.sv
// rtl/usb_rx_phy_ms.sv - multi-speed USB 1.1 receive PHY (DPLL, NRZI, unstuff, SYNC/EOP)
module usb_rx_phy_ms #(
    parameter int unsigned C_clk_input_hz = 48000000,
    parameter int unsigned C_PA_bits      = 10,
    parameter int unsigned C_PA_inc_fs    = 32'((64'd1 << C_PA_bits) * 64'd12000000 / 64'(C_clk_input_hz)),
    parameter int unsigned C_PA_inc_ls    = 32'((64'd1 << C_PA_bits) * 64'd1500000 / 64'(C_clk_input_hz))
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       speed_low,
    input  logic       usb_dif,
    input  logic       usb_dp,
    input  logic       usb_dn,
    input  logic       rx_en,
    output logic [1:0] linestate,
    output logic       clk_recovered_edge,
    output logic       rx_active,
    output logic       valid,
    output logic [7:0] data,
    output logic       rx_error,
    output logic       eop
);

    if (C_clk_input_hz < 48000000) begin : g_clk_check
        $error("usb_rx_phy_ms: C_clk_input_hz must be at least 48 MHz");
    end

    localparam int                   MSB    = C_PA_bits - 1;
    localparam logic [C_PA_bits-1:0] INC_FS = C_PA_bits'(C_PA_inc_fs);
    localparam logic [C_PA_bits-1:0] INC_LS = C_PA_bits'(C_PA_inc_ls);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN} state_t;

    logic dif_m, dif_s, dif_q, dp_m, dp_s, dn_m, dn_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            {dif_m, dif_s, dif_q, dp_m, dp_s, dn_m, dn_s} <= '0;
        end else begin
            dif_m <= usb_dif;
            dif_s <= dif_m;
            dif_q <= dif_s;
            dp_m  <= usb_dp;
            dp_s  <= dp_m;
            dn_m  <= usb_dn;
            dn_s  <= dn_m;
        end
    end

    assign linestate = {dn_s, dp_s};

    state_t               state, state_n;
    logic [C_PA_bits-1:0] pa_q, pa_next, inc;
    logic                 edge_q, prev_line, speed_q;
    logic [6:0]           hist, shift_q;
    logic [3:0]           fill;
    logic [2:0]           bitcnt, stuff_cnt;
    logic [7:0]           data_q, byte_next;
    logic                 valid_q, eop_q, err_q;
    logic                 se0, realign, strobe, nrzi_bit, is_stuff, sync_hit;
    logic                 take_bit, byte_done, set_eop, set_err;

    assign se0       = ~dp_s & ~dn_s;
    assign inc       = speed_q ? INC_LS : INC_FS;
    // Any data-line edge re-centres the sampling phase; SE0 edges are ignored.
    assign realign   = (dif_s != dif_q) && !se0;
    assign pa_next   = realign ? '0 : pa_q + inc;
    assign strobe    = pa_next[MSB] & ~pa_q[MSB];
    assign nrzi_bit  = (dif_s == prev_line);
    assign is_stuff  = (stuff_cnt == 3'd6);
    assign sync_hit  = (hist == 7'd0) && nrzi_bit && (fill >= 4'd7);
    assign byte_next = {nrzi_bit, shift_q};

    always_comb begin
        state_n   = state;
        take_bit  = 1'b0;
        byte_done = 1'b0;
        set_eop   = 1'b0;
        set_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (strobe && sync_hit)
                    state_n = S_DATA;
            end
            S_DATA: begin
                if (strobe) begin
                    if (se0) begin
                        state_n = S_IDLE;
                        if (bitcnt == 3'd0)
                            set_eop = 1'b1;
                        else
                            set_err = 1'b1;
                    end else if (is_stuff) begin
                        if (nrzi_bit) begin
                            set_err = 1'b1;
                            state_n = S_DRAIN;
                        end
                    end else begin
                        take_bit  = 1'b1;
                        byte_done = (bitcnt == 3'd7);
                    end
                end
            end
            S_DRAIN: begin
                if (strobe && se0)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !rx_en) begin
            state     <= S_IDLE;
            pa_q      <= '0;
            edge_q    <= 1'b0;
            prev_line <= 1'b0;
            speed_q   <= 1'b0;
            hist      <= '0;
            fill      <= '0;
            shift_q   <= '0;
            bitcnt    <= '0;
            stuff_cnt <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            eop_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state   <= state_n;
            pa_q    <= pa_next;
            edge_q  <= strobe;
            valid_q <= byte_done;
            eop_q   <= set_eop;
            err_q   <= set_err;
            if (strobe)
                prev_line <= dif_s;
            if (state == S_IDLE) begin
                speed_q   <= speed_low;
                bitcnt    <= '0;
                stuff_cnt <= '0;
                if (strobe) begin
                    hist <= {nrzi_bit, hist[6:1]};
                    if (fill != 4'd8)
                        fill <= fill + 4'd1;
                end
            end else begin
                fill <= '0;
            end
            if (state == S_DATA && strobe && !se0) begin
                if (is_stuff)
                    stuff_cnt <= '0;
                else
                    stuff_cnt <= nrzi_bit ? stuff_cnt + 3'd1 : 3'd0;
            end
            if (take_bit) begin
                shift_q <= byte_next[7:1];
                bitcnt  <= bitcnt + 3'd1;
                if (byte_done)
                    data_q <= byte_next;
            end
        end
    end

    assign clk_recovered_edge = edge_q;
    assign rx_active          = (state == S_DATA);
    assign valid              = valid_q;
    assign data               = data_q;
    assign rx_error           = err_q;
    assign eop                = eop_q;

endmodule

// File: tb/tb_usb_rx_phy_ms.sv
// tb/tb_usb_rx_phy_ms.sv - directed bench for usb_rx_phy_ms
`timescale 1ns/1ps
module tb_usb_rx_phy_ms;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       speed_low = 1'b0;
    logic       usb_dif = 1'b1;
    logic       usb_dp = 1'b1;
    logic       usb_dn = 1'b0;
    logic       rx_en = 1'b1;
    logic [1:0] linestate;
    logic       clk_recovered_edge, rx_active, valid, rx_error, eop;
    logic [7:0] data;

    always #10 clk = ~clk;

    usb_rx_phy_ms dut (
        .clk                (clk),
        .reset              (reset),
        .speed_low          (speed_low),
        .usb_dif            (usb_dif),
        .usb_dp             (usb_dp),
        .usb_dn             (usb_dn),
        .rx_en              (rx_en),
        .linestate          (linestate),
        .clk_recovered_edge (clk_recovered_edge),
        .rx_active          (rx_active),
        .valid              (valid),
        .data               (data),
        .rx_error           (rx_error),
        .eop                (eop)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0] rx_q[$];
    int         eop_cnt = 0;
    int         err_cnt = 0;
    int         act_fall = 0;
    logic       act_d = 1'b0;

    always @(negedge clk) begin
        if (valid) rx_q.push_back(data);
        if (eop) eop_cnt++;
        if (rx_error) err_cnt++;
        if (act_d && !rx_active) act_fall++;
        act_d = rx_active;
    end

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return {24'd0, rx_q[i]};
        return 32'hDEAD;
    endfunction

    bit  ls_pol = 1'b0;
    real bp = 80.0;
    bit  lvl = 1'b1;
    int  ones = 0;

    // st: 0 = K, 1 = J, 2 = SE0
    task automatic drive(input int st);
        logic dpv;
        if (st == 2) begin
            usb_dp = 1'b0; usb_dn = 1'b0; usb_dif = 1'b0;
        end else begin
            dpv = (st == 1) ^ ls_pol;
            usb_dp = dpv; usb_dn = !dpv; usb_dif = dpv;
        end
        #(bp);
    endtask

    task automatic send_nrzi(input bit b);
        if (!b) lvl = !lvl;
        drive(lvl ? 1 : 0);
    endtask

    task automatic idle(input int n);
        lvl = 1'b1;
        repeat (n) drive(1);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 8; i++) send_nrzi(i == 7);
        ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int toggle_at);
        for (int i = 0; i < 8; i++) begin
            if (i == toggle_at) speed_low = !speed_low;
            send_nrzi(b[i]);
            ones = b[i] ? ones + 1 : 0;
            if (ones == 6) begin
                send_nrzi(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic send_eop();
        drive(2);
        drive(2);
        idle(1);
    endtask

    int v0, e0, r0, a0;
    logic [7:0] pkt_p[8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    logic [7:0] pkt_m[8] = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

    task automatic snap();
        v0 = rx_q.size(); e0 = eop_cnt; r0 = err_cnt; a0 = act_fall;
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("rst_linestate", {30'd0, linestate}, 32'd0);
        check("rst_flags", {27'd0, rx_active, valid, eop, rx_error, clk_recovered_edge}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(6);
        check("fs_linestate_j", {30'd0, linestate}, 32'd1);

        // basic two-byte packet
        snap();
        send_sync(); send_byte(8'hA5, -1); send_byte(8'h3C, -1); send_eop(); idle(4);
        check("t1_nvalid", rx_q.size() - v0, 2);
        check("t1_b0", rx_at(v0), 8'hA5);
        check("t1_b1", rx_at(v0 + 1), 8'h3C);
        check("t1_eop", eop_cnt - e0, 1);
        check("t1_err", err_cnt - r0, 0);
        check("t1_data_hold", {24'd0, data}, 8'h3C);
        check("t1_active", {31'd0, rx_active}, 0);

        // stuffed payload, last byte completes on a 6th one
        snap();
        send_sync(); send_byte(8'hFF, -1); send_byte(8'hFF, -1); send_byte(8'hFC, -1);
        send_eop(); idle(4);
        check("t2_nvalid", rx_q.size() - v0, 3);
        check("t2_b0", rx_at(v0), 8'hFF);
        check("t2_b1", rx_at(v0 + 1), 8'hFF);
        check("t2_b2", rx_at(v0 + 2), 8'hFC);
        check("t2_err", err_cnt - r0, 0);
        check("t2_act_fall", act_fall - a0, 1);
        check("t2_eop", eop_cnt - e0, 1);

        // stuff error, drain ignores a SYNC until SE0
        snap();
        send_sync(); send_byte(8'hFF, -1);
        repeat (5) send_nrzi(1'b1);
        send_nrzi(1'b0);
        send_sync(); send_byte(8'h11, -1);
        check("t3_nvalid_drain", rx_q.size() - v0, 1);
        check("t3_b0", rx_at(v0), 8'hFF);
        check("t3_err", err_cnt - r0, 1);
        check("t3_active", {31'd0, rx_active}, 0);
        check("t3_eop_drain", eop_cnt - e0, 0);
        send_eop(); idle(3);
        send_sync(); send_byte(8'h11, -1); send_eop(); idle(4);
        check("t3_nvalid", rx_q.size() - v0, 2);
        check("t3_b1", rx_at(v0 + 1), 8'h11);
        check("t3_eop", eop_cnt - e0, 1);

        // framing error after 12 bits
        snap();
        send_sync(); send_byte(8'h96, -1);
        send_nrzi(1'b1); send_nrzi(1'b1); send_nrzi(1'b0); send_nrzi(1'b0);
        send_eop(); idle(4);
        check("t4_nvalid", rx_q.size() - v0, 1);
        check("t4_b0", rx_at(v0), 8'h96);
        check("t4_err", err_cnt - r0, 1);
        check("t4_eop", eop_cnt - e0, 0);
        check("t4_active", {31'd0, rx_active}, 0);
        send_sync(); send_byte(8'h42, -1); send_eop(); idle(4);
        check("t4_recover", rx_at(v0 + 1), 8'h42);

        // low speed, inverted J, speed_low toggled mid-frame
        speed_low = 1'b1; ls_pol = 1'b1; bp = 640.0;
        idle(4);
        check("ls_linestate_j", {30'd0, linestate}, 32'd2);
        snap();
        send_sync(); send_byte(8'h5A, 4); send_byte(8'hC3, 3);
        speed_low = 1'b1;
        send_eop(); idle(2);
        check("t5_nvalid", rx_q.size() - v0, 2);
        check("t5_b0", rx_at(v0), 8'h5A);
        check("t5_b1", rx_at(v0 + 1), 8'hC3);
        check("t5_eop", eop_cnt - e0, 1);
        check("t5_err", err_cnt - r0, 0);

        // full speed with +/-0.25% bit rate
        speed_low = 1'b0; ls_pol = 1'b0; bp = 80.2;
        idle(6);
        snap();
        send_sync();
        for (int i = 0; i < 8; i++) send_byte(pkt_p[i], -1);
        send_eop(); idle(4);
        check("t6p_nvalid", rx_q.size() - v0, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t6p_b%0d", i), rx_at(v0 + i), pkt_p[i]);
        check("t6p_eop", eop_cnt - e0, 1);
        bp = 79.8;
        snap();
        send_sync();
        for (int i = 0; i < 8; i++) send_byte(pkt_m[i], -1);
        send_eop(); idle(4);
        check("t6m_nvalid", rx_q.size() - v0, 8);
        for (int i = 0; i < 8; i++) check($sformatf("t6m_b%0d", i), rx_at(v0 + i), pkt_m[i]);
        check("t6m_eop", eop_cnt - e0, 1);
        check("t6_err", err_cnt - r0, 0);

        // rx_en dropped mid-byte
        bp = 80.0;
        snap();
        send_sync(); send_byte(8'h77, -1);
        send_nrzi(1'b1); send_nrzi(1'b0); send_nrzi(1'b1);
        check("t6en_b0", rx_at(v0), 8'h77);
        v0 = rx_q.size(); e0 = eop_cnt; r0 = err_cnt;
        rx_en = 1'b0;
        for (int i = 0; i < 5; i++) send_nrzi(1'b0);
        send_byte(8'h33, -1); send_eop(); idle(4);
        check("t6en_nvalid", rx_q.size() - v0, 0);
        check("t6en_eop", eop_cnt - e0, 0);
        check("t6en_err", err_cnt - r0, 0);
        check("t6en_data", {24'd0, data}, 0);
        check("t6en_active", {31'd0, rx_active}, 0);
        check("t6en_linestate", {30'd0, linestate}, 32'd1);
        rx_en = 1'b1;
        idle(4);
        check("t6en_reenable", {31'd0, rx_active}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
